// File: rtl/clock_enable_gen_pkg.sv
// Shared definitions for the clock-enable generator: channel mode encodings and
// the width of the channel index.
package clock_enable_gen_pkg;

    localparam logic MODE_INT  = 1'b0;
    localparam logic MODE_FRAC = 1'b1;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_enable_gen_channel.sv
// One clock-enable channel: integer divider or fractional phase accumulator,
// with an active/shadow ratio pair that swaps only at the channel's wrap.
module clock_enable_gen_channel
    import clock_enable_gen_pkg::*;
#(
    parameter int               CNT_W    = 24,
    parameter logic [CNT_W-1:0] DEF_DIV  = '0,
    parameter logic             DEF_MODE = MODE_INT
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic             wr_mode,
    input  logic [CNT_W-1:0] wr_val,
    output logic             tick,
    output logic             level
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_val;
    logic [CNT_W-1:0] shd_val;
    logic             act_mode;
    logic             shd_mode;
    logic [CNT_W-1:0] n_last;
    logic [CNT_W:0]   sum;
    logic             wrap;
    logic [CNT_W-1:0] cnt_nxt;

    // A ratio of zero behaves as one, so the last count is 0 in both cases.
    always_comb begin
        n_last  = (act_val == '0) ? '0 : act_val - CNT_W'(1);
        sum     = {1'b0, cnt} + {1'b0, act_val};
        wrap    = 1'b0;
        cnt_nxt = cnt;
        if (act_mode == MODE_FRAC) begin
            wrap    = sum[CNT_W];
            cnt_nxt = sum[CNT_W-1:0];
        end else begin
            wrap    = (cnt >= n_last);
            cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt      <= '0;
            act_val  <= DEF_DIV;
            act_mode <= DEF_MODE;
            shd_val  <= DEF_DIV;
            shd_mode <= DEF_MODE;
            tick     <= 1'b0;
            level    <= 1'b0;
        end else begin
            if (wr) begin
                shd_val  <= wr_val;
                shd_mode <= wr_mode;
            end
            if (sync) begin
                // A write in the sync cycle is loaded straight through to active.
                cnt      <= '0;
                tick     <= 1'b0;
                level    <= 1'b0;
                act_val  <= wr ? wr_val  : shd_val;
                act_mode <= wr ? wr_mode : shd_mode;
            end else if (en) begin
                tick <= wrap;
                if (wrap) begin
                    level    <= ~level;
                    act_val  <= shd_val;
                    act_mode <= shd_mode;
                    cnt      <= (shd_mode != act_mode) ? '0 : cnt_nxt;
                end else begin
                    cnt <= cnt_nxt;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: config decode, ack/err strobes and
// fan-out of the shared run/sync controls to the per-channel dividers.
module clock_enable_gen
    import clock_enable_gen_pkg::*;
#(
    parameter int                   NCH      = 3,
    parameter int                   CNT_W    = 24,
    parameter logic [NCH*CNT_W-1:0] DEF_DIV  = {24'd1666667, 24'd262144, 24'd4},
    parameter logic [NCH-1:0]       DEF_MODE = 3'b000,
    localparam int                  CH_W     = ch_w(NCH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic             cfg_mode,
    input  logic [CNT_W-1:0] cfg_val,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   level
);

    localparam logic [CH_W:0] NCH_C = (CH_W+1)'(NCH);

    logic           ch_ok;
    logic [NCH-1:0] wr;

    assign ch_ok = ({1'b0, cfg_ch} < NCH_C);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_we && ch_ok;
            cfg_err <= cfg_we && !ch_ok;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr[i] = cfg_we && (cfg_ch == CH_W'(i));

        clock_enable_gen_channel #(
            .CNT_W    (CNT_W),
            .DEF_DIV  (DEF_DIV[i*CNT_W +: CNT_W]),
            .DEF_MODE (DEF_MODE[i])
        ) u_ch (
            .clk     (clk),
            .clr_n   (clr_n),
            .en      (en),
            .sync    (sync),
            .wr      (wr[i]),
            .wr_mode (cfg_mode),
            .wr_val  (cfg_val),
            .tick    (tick[i]),
            .level   (level[i])
        );
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen with default parameters (ch0 /4, ch1 /262144, ch2 /1666667).
module tb_clock_enable_gen;

    localparam int NCH   = 3;
    localparam int CNT_W = 24;

    logic             clk      = 1'b0;
    logic             clr_n    = 1'b0;
    logic             en       = 1'b0;
    logic             sync     = 1'b0;
    logic             cfg_we   = 1'b0;
    logic [1:0]       cfg_ch   = '0;
    logic             cfg_mode = 1'b0;
    logic [CNT_W-1:0] cfg_val  = '0;
    logic             cfg_ack;
    logic             cfg_err;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   level;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    clock_enable_gen dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (en),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_val  (cfg_val),
        .cfg_ack  (cfg_ack),
        .cfg_err  (cfg_err),
        .tick     (tick),
        .level    (level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench #1 after an edge with reset released; the next edge is edge 1.
    task automatic do_reset();
        clr_n  = 1'b0;
        en     = 1'b0;
        sync   = 1'b0;
        cfg_we = 1'b0;
        step();
        step();
        check("rst_tick",  32'(tick),    32'd0);
        check("rst_level", 32'(level),   32'd0);
        check("rst_ack",   32'(cfg_ack), 32'd0);
        check("rst_err",   32'(cfg_err), 32'd0);
        en    = 1'b1;
        clr_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic mode, input logic [CNT_W-1:0] val);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = mode;
        cfg_val  = val;
    endtask

    initial begin
        int ntick;

        // Defaults: ch0 ticks every 4 edges, level period 8; ch1/ch2 silent this early.
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t1_tick0 k=%0d", k), 32'(tick[0]), 32'((k % 4) == 0));
            check($sformatf("t1_lvl0 k=%0d", k), 32'(level[0]), 32'((k >= 4 && k < 8) || k >= 12));
            check($sformatf("t1_tick12 k=%0d", k), 32'(tick[2:1]), 32'd0);
        end

        // ch0 reprogrammed to N=10 mid-period: current period completes first.
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            step();
            check($sformatf("t2_tick0 k=%0d", k), 32'(tick[0]), 32'(k == 4 || k == 8 || k == 18 || k == 28));
            if (k <= 10) check($sformatf("t2_ack k=%0d", k), 32'(cfg_ack), 32'(k == 7));
            if (k == 6) cfg_write(2'd0, 1'b0, 24'd10);
            if (k == 7) cfg_we = 1'b0;
        end

        // ch2 FRAC INC=2^22 loaded via sync write-through: exact period 4.
        do_reset();
        cfg_write(2'd2, 1'b1, 24'h400000);
        sync = 1'b1;
        step();
        check("t3_ack", 32'(cfg_ack), 32'd1);
        cfg_we = 1'b0;
        sync   = 1'b0;
        for (int k = 2; k <= 13; k++) begin
            step();
            check($sformatf("t3_tick2 k=%0d", k), 32'(tick[2]), 32'(k >= 5 && ((k - 5) % 4) == 0));
        end
        // INC=0x555555 averages one tick per three cycles.
        cfg_write(2'd2, 1'b1, 24'h555555);
        sync = 1'b1;
        step();
        cfg_we = 1'b0;
        sync   = 1'b0;
        ntick  = 0;
        for (int k = 0; k < 3000; k++) begin
            step();
            ntick += int'(tick[2]);
        end
        check("t3_frac_count", 32'(ntick >= 999 && ntick <= 1001), 32'd1);

        // en low for edges 6..10: ch0 tick moves from edge 8 to 13, level held at 1.
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            step();
            check($sformatf("t4_tick0 k=%0d", k), 32'(tick[0]), 32'(k == 4 || k == 13 || k == 17));
            check($sformatf("t4_lvl0 k=%0d", k), 32'(level[0]), 32'((k >= 4 && k < 13) || k >= 17));
            if (k == 5)  en = 1'b0;
            if (k == 10) en = 1'b1;
        end

        // sync together with a write of ch1 N=2 at edge 6.
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 5) check("t5_lvl0_pre", 32'(level[0]), 32'd1);
            if (k == 6) begin
                check("t5_level", 32'(level), 32'd0);
                check("t5_ack",   32'(cfg_ack), 32'd1);
                check("t5_tick",  32'(tick), 32'd0);
            end
            if (k >= 7) begin
                check($sformatf("t5_tick1 k=%0d", k), 32'(tick[1]), 32'((k % 2) == 0));
                check($sformatf("t5_tick0 k=%0d", k), 32'(tick[0]), 32'(k == 10));
            end
            if (k == 5) begin
                cfg_write(2'd1, 1'b0, 24'd2);
                sync = 1'b1;
            end
            if (k == 6) begin
                cfg_we = 1'b0;
                sync   = 1'b0;
            end
        end

        // Out-of-range channel write, then asynchronous reset mid-run.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("t6_err k=%0d", k), 32'(cfg_err), 32'(k == 2));
            check($sformatf("t6_ack k=%0d", k), 32'(cfg_ack), 32'd0);
            check($sformatf("t6_tick k=%0d", k), 32'(tick), (k == 4) ? 32'd1 : 32'd0);
            if (k == 1) cfg_write(2'd3, 1'b0, 24'd1);
            if (k == 2) cfg_we = 1'b0;
        end
        check("t6_lvl_pre", 32'(level[0]), 32'd1);
        clr_n = 1'b0;
        #2;
        check("t6_async_tick",  32'(tick),    32'd0);
        check("t6_async_level", 32'(level),   32'd0);
        check("t6_async_ack",   32'(cfg_ack), 32'd0);
        check("t6_async_err",   32'(cfg_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
